// File: rtl/pipelinediv_result_collector.sv
// Result collector for the pipelined divider: token tracking, sign/divide-by-zero fix-up and a credit-gated result FIFO.
// Optional build macro DIV_DBZ_COUNT_EN adds a saturating dbz_count output.
module pipelinediv_result_collector #(
  parameter int DIVIDENDLEN = 16,
  parameter int DIVISORLEN  = 8,
  parameter int LATENCY     = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   issue_qneg,
  input  logic                   issue_rneg,
  input  logic                   issue_dbz,
  input  logic [DIVIDENDLEN-1:0] div_quotient,
  input  logic [DIVISORLEN-1:0]  div_remainder,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DIVIDENDLEN-1:0] res_quotient,
  output logic [DIVISORLEN-1:0]  res_remainder,
  output logic                   res_dbz
`ifdef DIV_DBZ_COUNT_EN
  ,
  output logic [7:0]             dbz_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int UW = PW + 1;

  function automatic logic [DIVIDENDLEN-1:0] fix_quotient(
    input logic [DIVIDENDLEN-1:0] q,
    input logic                   neg,
    input logic                   dbz
  );
    logic [DIVIDENDLEN-1:0] res;
    if (dbz) begin
      res = '1;
    end else if (neg) begin
      res = -q;
    end else begin
      res = q;
    end
    return res;
  endfunction

  function automatic logic [DIVISORLEN-1:0] fix_remainder(
    input logic [DIVISORLEN-1:0] r,
    input logic                  neg,
    input logic                  dbz
  );
    logic [DIVISORLEN-1:0] res;
    if (dbz) begin
      res = r;
    end else if (neg) begin
      res = -r;
    end else begin
      res = r;
    end
    return res;
  endfunction

  logic [LATENCY-1:0]     tok_v_r;
  logic [LATENCY-1:0]     tok_qneg_r;
  logic [LATENCY-1:0]     tok_rneg_r;
  logic [LATENCY-1:0]     tok_dbz_r;

  logic [DIVIDENDLEN-1:0] mem_q_r [FIFO_DEPTH];
  logic [DIVISORLEN-1:0]  mem_r_r [FIFO_DEPTH];
  logic                   mem_z_r [FIFO_DEPTH];
  logic [UW-1:0]          wr_ptr_r;
  logic [UW-1:0]          rd_ptr_r;
  logic [UW-1:0]          used_r;

  logic                   accept_s;
  logic                   pop_s;
  logic                   exit_s;
  logic                   push_s;
  logic                   empty_s;
  logic                   full_s;
  logic [DIVIDENDLEN-1:0] fix_q_s;
  logic [DIVISORLEN-1:0]  fix_r_s;
  logic                   fix_z_s;

  assign accept_s    = issue_valid && issue_ready;
  assign pop_s       = res_valid && res_ready;
  assign exit_s      = tok_v_r[LATENCY-1];
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign push_s      = exit_s && !full_s;
  assign issue_ready = (used_r < UW'(FIFO_DEPTH));
  assign res_valid   = !empty_s;

  // Correct the divider output using the flags carried by the exiting token
  always_comb begin
    fix_q_s = fix_quotient(div_quotient, tok_qneg_r[LATENCY-1], tok_dbz_r[LATENCY-1]);
    fix_r_s = fix_remainder(div_remainder, tok_rneg_r[LATENCY-1], tok_dbz_r[LATENCY-1]);
    fix_z_s = tok_dbz_r[LATENCY-1];
  end

  // Token pipe mirrors the divider latency so each result is captured on its exit cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      tok_v_r    <= '0;
      tok_qneg_r <= '0;
      tok_rneg_r <= '0;
      tok_dbz_r  <= '0;
    end else begin
      tok_v_r    <= {tok_v_r[LATENCY-2:0], accept_s};
      tok_qneg_r <= {tok_qneg_r[LATENCY-2:0], issue_qneg};
      tok_rneg_r <= {tok_rneg_r[LATENCY-2:0], issue_rneg};
      tok_dbz_r  <= {tok_dbz_r[LATENCY-2:0], issue_dbz};
    end
  end

  // Result storage; no reset needed since only entries behind the pointers are read
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_q_r[wr_ptr_r[PW-1:0]] <= fix_q_s;
      mem_r_r[wr_ptr_r[PW-1:0]] <= fix_r_s;
      mem_z_r[wr_ptr_r[PW-1:0]] <= fix_z_s;
    end
  end

  // FIFO pointers carry an extra MSB to tell full from empty
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + UW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + UW'(1) : rd_ptr_r;
    end
  end

  // Credits cover in-flight tokens plus buffered results, so an exit always finds room
  always_ff @(posedge clock) begin
    if (reset) begin
      used_r <= '0;
    end else if (accept_s && !pop_s) begin
      used_r <= used_r + UW'(1);
    end else if (!accept_s && pop_s) begin
      used_r <= used_r - UW'(1);
    end else begin
      used_r <= used_r;
    end
  end

  // Head of FIFO presented directly; zeros while empty
  always_comb begin
    if (empty_s) begin
      res_quotient  = '0;
      res_remainder = '0;
      res_dbz       = 1'b0;
    end else begin
      res_quotient  = mem_q_r[rd_ptr_r[PW-1:0]];
      res_remainder = mem_r_r[rd_ptr_r[PW-1:0]];
      res_dbz       = mem_z_r[rd_ptr_r[PW-1:0]];
    end
  end

`ifdef DIV_DBZ_COUNT_EN
  // Saturating count of divide-by-zero results entering the buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      dbz_count <= 8'h00;
    end else if (push_s && fix_z_s && (dbz_count != 8'hFF)) begin
      dbz_count <= dbz_count + 8'h01;
    end else begin
      dbz_count <= dbz_count;
    end
  end
`endif

  // An exit into a full buffer means the credit accounting is broken
  always @(posedge clock) begin
    if (!reset && exit_s) begin
      assert (!full_s) else $error("pipelinediv_result_collector: token exit with result buffer full");
    end
  end

endmodule

// File: tb/tb_pipelinediv_result_collector.sv
// Directed self-checking bench for pipelinediv_result_collector (LATENCY=16, FIFO_DEPTH=4).
module tb_pipelinediv_result_collector;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_qneg;
  logic        issue_rneg;
  logic        issue_dbz;
  logic [15:0] div_quotient;
  logic [7:0]  div_remainder;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_quotient;
  logic [7:0]  res_remainder;
  logic        res_dbz;
`ifdef DIV_DBZ_COUNT_EN
  logic [7:0]  dbz_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipelinediv_result_collector #(
    .DIVIDENDLEN(16), .DIVISORLEN(8), .LATENCY(16), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_qneg(issue_qneg), .issue_rneg(issue_rneg), .issue_dbz(issue_dbz),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_quotient(res_quotient), .res_remainder(res_remainder), .res_dbz(res_dbz)
`ifdef DIV_DBZ_COUNT_EN
    , .dbz_count(dbz_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op, present div_* on its exit cycle, check the corrected head, then pop it.
  task automatic run_one(input string tag, input logic qn, input logic rn, input logic dz,
                         input logic [15:0] dq, input logic [7:0] dr,
                         input logic [15:0] eq, input logic [7:0] er, input logic ez);
    issue_qneg = qn; issue_rneg = rn; issue_dbz = dz;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0; issue_qneg = 1'b0; issue_rneg = 1'b0; issue_dbz = 1'b0;
    steps(15);
    chk({tag, "_early_valid"}, 32'(res_valid), 32'd0);
    div_quotient = dq; div_remainder = dr;
    step();
    div_quotient = 16'hDEAD; div_remainder = 8'hBE;
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_quot"}, 32'(res_quotient), 32'(eq));
    chk({tag, "_rem"}, 32'(res_remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(res_dbz), 32'(ez));
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk({tag, "_popped"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; issue_qneg = 1'b0; issue_rneg = 1'b0; issue_dbz = 1'b0;
    div_quotient = 16'h1234; div_remainder = 8'h56; res_ready = 1'b0;
    steps(2);
    reset = 1'b0;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_quot", 32'(res_quotient), 32'd0);
    chk("rst_res_rem", 32'(res_remainder), 32'd0);
    chk("rst_res_dbz", 32'(res_dbz), 32'd0);

    // Basic, negated, divide-by-zero and remainder-only-negated cases
    run_one("t1_plain", 1'b0, 1'b0, 1'b0, 16'd14, 8'd2, 16'd14, 8'd2, 1'b0);
    run_one("t2_neg", 1'b1, 1'b1, 1'b0, 16'd14, 8'd2, 16'hFFF2, 8'hFE, 1'b0);
    run_one("t3_dbz", 1'b1, 1'b0, 1'b1, 16'hFFFF, 8'h05, 16'hFFFF, 8'h05, 1'b1);
    run_one("t3b_dbz_rneg", 1'b0, 1'b1, 1'b1, 16'h0000, 8'h07, 16'hFFFF, 8'h07, 1'b1);
    run_one("t3c_rneg", 1'b0, 1'b1, 1'b0, 16'd9, 8'd1, 16'd9, 8'hFF, 1'b0);

    // Test 4: credit exhaustion with consumer stalled, then in-order drain
    issue_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t4_ready_c%0d", c), 32'(issue_ready), (c < 4) ? 32'd1 : 32'd0);
      issue_qneg = (c == 2);
      step();
    end
    issue_valid = 1'b0; issue_qneg = 1'b0;
    steps(10);
    for (int i = 0; i < 4; i++) begin
      div_quotient = 16'(100 + i); div_remainder = 8'(10 + i);
      step();
    end
    div_quotient = 16'h1234; div_remainder = 8'h56;
    chk("t4_full_valid", 32'(res_valid), 32'd1);
    chk("t4_full_ready", 32'(issue_ready), 32'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_quot_%0d", i), 32'(res_quotient), (i == 2) ? 32'h0000FF9A : 32'(100 + i));
      chk($sformatf("t4_rem_%0d", i), 32'(res_remainder), 32'(10 + i));
      step();
    end
    res_ready = 1'b0;
    chk("t4_drained_valid", 32'(res_valid), 32'd0);
    chk("t4_drained_ready", 32'(issue_ready), 32'd1);

    // Test 5: used=3, simultaneous issue+pop, then issue only; drain with exit/pop overlap
    issue_valid = 1'b1;
    steps(3);
    issue_valid = 1'b0;
    steps(13);
    for (int i = 0; i < 3; i++) begin
      div_quotient = 16'(200 + i); div_remainder = 8'(20 + i);
      step();
    end
    div_quotient = 16'h1234; div_remainder = 8'h56;
    chk("t5_used3_ready", 32'(issue_ready), 32'd1);
    chk("t5_head0", 32'(res_quotient), 32'd200);
    issue_valid = 1'b1; res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("t5_issue_pop_ready", 32'(issue_ready), 32'd1);
    chk("t5_issue_pop_head", 32'(res_quotient), 32'd201);
    step();
    issue_valid = 1'b0;
    chk("t5_issue_only_ready", 32'(issue_ready), 32'd0);
    steps(14);
    chk("t5_pre_exit_head", 32'(res_quotient), 32'd201);
    div_quotient = 16'd300; div_remainder = 8'd30; res_ready = 1'b1;
    step();
    chk("t5_overlap_head1", 32'(res_quotient), 32'd202);
    div_quotient = 16'd301; div_remainder = 8'd31;
    step();
    div_quotient = 16'h1234; div_remainder = 8'h56;
    chk("t5_overlap_head2", 32'(res_quotient), 32'd300);
    chk("t5_overlap_rem2", 32'(res_remainder), 32'd30);
    step();
    chk("t5_last_head", 32'(res_quotient), 32'd301);
    step();
    res_ready = 1'b0;
    chk("t5_drained_valid", 32'(res_valid), 32'd0);
    chk("t5_drained_ready", 32'(issue_ready), 32'd1);

    // Test 6: reset with tokens in flight discards them
    issue_valid = 1'b1;
    steps(3);
    issue_valid = 1'b0;
    steps(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_ready_after_rst", 32'(issue_ready), 32'd1);
    div_quotient = 16'h4444; div_remainder = 8'h44;
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("t6_valid_c%0d", i), 32'(res_valid), 32'd0);
      step();
    end
    chk("t6_final_ready", 32'(issue_ready), 32'd1);
    chk("t6_final_quot", 32'(res_quotient), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
